// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg : opcode and FSM state encodings shared by the multi-cycle ALU     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_MULU = 4'b0100;
  localparam logic [3:0] ALU_DIVU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mc_alu_muldiv.sv
// +----------------------------------------------------------------------------+
// | mc_alu_muldiv : iterative one-bit-per-cycle shift-add multiplier and       |
// |                 restoring divider (divider present with MC_ALU_DIV_EN)     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
`ifdef MC_ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
`ifdef MC_ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   trial;
`endif

  // lo/hi outputs carry the result of the iteration in progress, so the
  // caller can capture the final value on the same edge that completes it.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], lo_q[WIDTH-1:1]};
`ifdef MC_ALU_DIV_EN
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign lo_o   = step_lo;
  assign hi_o   = step_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MC_ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      hi_q   <= '0;
`ifdef MC_ALU_DIV_EN
      div_q  <= div_i;
      lo_q   <= div_i ? a_i : b_i;
      opnd_q <= div_i ? b_i : a_i;
`else
      lo_q   <= b_i;
      opnd_q <= a_i;
`endif
    end else if (busy_q) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mc_alu.sv
// +----------------------------------------------------------------------------+
// | mc_alu : handshaked multi-cycle ALU with registered results held until     |
// |          consumed; divu is built only when MC_ALU_DIV_EN is defined        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic             dz_q, dz_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, simple_res;
  logic             simple_ovf, simple_ill;
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;
`ifdef MC_ALU_DIV_EN
  logic             md_div;
`endif

  assign shamt = in2[SHW-1:0];
  assign sum   = in1 + in2;
  assign diff  = in1 - in2;

  // mulu/divu land in the default arm here; the FSM intercepts them first,
  // so only a divu in a divider-less build reaches this path as illegal.
  always_comb begin
    simple_res = '0;
    simple_ovf = 1'b0;
    simple_ill = 1'b0;
    case (operation)
      ALU_AND:  simple_res = in1 & in2;
      ALU_OR:   simple_res = in1 | in2;
      ALU_XOR:  simple_res = in1 ^ in2;
      ALU_NOR:  simple_res = ~(in1 | in2);
      ALU_ADD: begin
        simple_res = sum;
        simple_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_SUB: begin
        simple_res = diff;
        simple_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      ALU_SLL:  simple_res = in1 << shamt;
      ALU_SRL:  simple_res = in1 >> shamt;
      ALU_SRA:  simple_res = $signed(in1) >>> shamt;
      default:  simple_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    dz_d     = dz_q;
    md_start = 1'b0;
`ifdef MC_ALU_DIV_EN
    md_div   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          hi_d  = '0;
          ovf_d = 1'b0;
          ill_d = 1'b0;
          dz_d  = 1'b0;
          if (operation == ALU_MULU) begin
            md_start = 1'b1;
            state_d  = S_MUL;
          end
`ifdef MC_ALU_DIV_EN
          else if (operation == ALU_DIVU) begin
            if (in2 == '0) begin
              out_d   = '1;
              hi_d    = in1;
              zero_d  = 1'b0;
              dz_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              md_start = 1'b1;
              md_div   = 1'b1;
              state_d  = S_DIV;
            end
          end
`endif
          else begin
            out_d   = simple_res;
            zero_d  = (simple_res == '0);
            ovf_d   = simple_ovf;
            ill_d   = simple_ill;
            state_d = S_DONE;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (md_done) begin
          out_d   = md_lo;
          hi_d    = md_hi;
          zero_d  = (md_lo == '0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
      dz_q    <= dz_d;
    end
  end

  mc_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start),
`ifdef MC_ALU_DIV_EN
    .div_i   (md_div),
`endif
    .a_i     (in1),
    .b_i     (in2),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;
  assign div_zero  = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_alu.sv
// +----------------------------------------------------------------------------+
// | tb_mc_alu : directed and random stimulus for mc_alu against an arithmetic  |
// |             reference model; honours MC_ALU_DIV_EN                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mc_alu;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] in1, in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out, hi;
  logic        zero, overflow, illegal, div_zero;

  int evals = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] out;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic        dz;
    int          lat;
  } exp_t;

  mc_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .hi        (hi),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    evals++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      s;
    logic [63:0] p;
    e.out = '0; e.hi = '0; e.ovf = 1'b0; e.ill = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      4'd0:  e.out = a & b;
      4'd1:  e.out = a | b;
      4'd2: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.out = a + b;
        e.ovf = (s > SMAX) || (s < SMIN);
      end
      4'd3:  e.out = a ^ b;
      4'd4: begin
        p = {32'd0, a} * {32'd0, b};
        e.out = p[31:0];
        e.hi  = p[63:32];
        e.lat = 33;
      end
      4'd5: begin
`ifdef MC_ALU_DIV_EN
        if (b == 0) begin
          e.out = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
        end else begin
          e.out = a / b; e.hi = a % b; e.lat = 33;
        end
`else
        e.ill = 1'b1;
`endif
      end
      4'd6: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.out = a - b;
        e.ovf = (s > SMAX) || (s < SMIN);
      end
      4'd7:  e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  e.out = a << b[4:0];
      4'd9:  e.out = a >> b[4:0];
      4'd10: e.out = $signed(a) >>> b[4:0];
      4'd11: e.out = (a < b) ? 32'd1 : 32'd0;
      4'd12: e.out = ~(a | b);
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.out == 0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input string tag);
    exp_t e;
    int   lat;
    e = model(op, a, b);
    wait_ready(tag);
    in_valid = 1'b1; operation = op; in1 = a; in2 = b;
    @(posedge clk); #1;
    // Junk requests while busy must be ignored and operands must stay latched.
    operation = 4'($urandom); in1 = $urandom; in2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"},  64'(lat), 64'(e.lat));
    check({tag, "_out"},  out,      e.out);
    check({tag, "_hi"},   hi,       e.hi);
    check({tag, "_flags"}, {zero, overflow, illegal, div_zero}, {e.zero, e.ovf, e.ill, e.dz});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, {in_ready, out_valid, out, hi, zero, overflow, illegal, div_zero},
                            {1'b0, 1'b1, e.out, e.hi, e.zero, e.ovf, e.ill, e.dz});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_handoff"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operation = '0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_state", {in_ready, out_valid, out, hi, zero, overflow, illegal, div_zero},
                         {1'b1, 1'b0, 32'd0, 32'd0, 4'd0});

    run_op(4'd2,  32'h7FFF_FFFF, 32'd1,         0, "add_ovf");
    run_op(4'd6,  32'd5,         32'd5,         0, "sub_zero");
    run_op(4'd10, 32'hF000_0000, 32'd4,         0, "sra");
    run_op(4'd11, 32'd1,         32'hFFFF_FFFF, 0, "sltu");
    run_op(4'd7,  32'hFFFF_FFFF, 32'd1,         0, "slt");
    run_op(4'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulu_max");
    run_op(4'd5,  32'd100,       32'd7,         0, "divu");
    run_op(4'd5,  32'd5,         32'd0,         0, "divu_zero");
    run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0, "illegal_f");
    run_op(4'd6,  32'h8000_0000, 32'd1,         5, "sub_ovf_stall");

    // Reset during the tenth cycle of a multiply discards it.
    wait_ready("rst_mul");
    in_valid = 1'b1; operation = 4'd4; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mul_state", {in_ready, out_valid, out, hi, zero, overflow, illegal, div_zero},
                           {1'b1, 1'b0, 32'd0, 32'd0, 4'd0});
    repeat (40) @(posedge clk);
    #1 check("rst_mul_discard", out_valid, 0);

    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (n % 4 == 0) op = 4'd4;
      if (n % 4 == 1) op = 4'd5;
      run_op(op, pick(), pick(), $urandom_range(0, 2), $sformatf("rand%0d_op%0d", n, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule

`default_nettype wire
